// File: rtl/retire_trace_sink.sv
// retire_trace_sink
//   Consumer end of the core retirement interface. Every retire strobe is
//   captured into a DEPTH-entry FIFO together with an 8-bit sequence number,
//   and each entry is then sent as a 6-beat valid/ready stream:
//     HDR, PC, INSTR, RDATA, MADDR, MDATA
//   The core cannot be stalled. A packet that arrives while the FIFO is full
//   is dropped, and the sticky overflow flag is set.
//
//   Ports
//     clk_i, rst_i        clock, asynchronous active-high reset
//     update_i            retire strobe (qualifies the retire fields below)
//     pc_i, instr_i       retired PC / instruction
//     reg_addr_i/data_i   retired rd / rd data
//     mem_addr_i/data_i   retired memory address / write data
//     mem_wrt_i           retired memory write enable
//     tvalid_o/tready_i   stream handshake
//     tdata_o, tlast_o    stream beat, final-beat marker
//     level_o             FIFO occupancy, including the packet being sent
//     overflow_o          sticky drop flag
//     drop_cnt_o          saturating drop counter
//
//   Build option
//     TRACE_DROP_CNT_EN   builds the drop counter; drop_cnt_o is 0 otherwise
module retire_trace_sink #(
  parameter int         XLEN    = 32,
  parameter int         DEPTH   = 8,
  parameter logic [7:0] HDR_TAG = 8'hA5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     update_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [XLEN-1:0]          instr_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [XLEN-1:0]          reg_data_i,
  input  logic [XLEN-1:0]          mem_addr_i,
  input  logic [XLEN-1:0]          mem_data_i,
  input  logic                     mem_wrt_i,
  output logic                     tvalid_o,
  input  logic                     tready_i,
  output logic [XLEN-1:0]          tdata_o,
  output logic                     tlast_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PC, S_INSTR, S_RDATA, S_MADDR, S_MDATA
  } state_t;

  typedef struct packed {
    logic [7:0]      seq;
    logic            mem_wrt;
    logic [4:0]      reg_addr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] reg_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW:0]     wptr_q, rptr_q, rptr_inc;
  logic [AW:0]     count_q;
  logic [7:0]      seq_q;
  state_t          state_q;
  logic [XLEN-1:0] tdata_q;
  logic            overflow_q;
  logic            full, empty, hs, pop, push, drop;
  entry_t          wr_entry, head_cur, head_nxt;

  // Beat payload for a given state, taken from one FIFO entry.
  function automatic logic [XLEN-1:0] beat_sel(input state_t s, input entry_t e);
    logic [XLEN-1:0] b;
    b = '0;
    case (s)
      S_HDR:   b = {HDR_TAG, e.seq, 10'd0, e.mem_wrt, e.reg_addr};
      S_PC:    b = e.pc;
      S_INSTR: b = e.instr;
      S_RDATA: b = e.reg_data;
      S_MADDR: b = e.mem_addr;
      S_MDATA: b = e.mem_data;
      default: b = '0;
    endcase
    return b;
  endfunction

  function automatic state_t next_beat(input state_t s);
    state_t n;
    n = S_IDLE;
    case (s)
      S_HDR:   n = S_PC;
      S_PC:    n = S_INSTR;
      S_INSTR: n = S_RDATA;
      S_RDATA: n = S_MADDR;
      S_MADDR: n = S_MDATA;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign hs       = tvalid_o && tready_i;
  assign pop      = (state_q == S_MDATA) && hs;
  // A full FIFO still accepts a push when the head is freed on the same edge.
  assign push     = update_i && (!full || pop);
  assign drop     = update_i && full && !pop;
  assign rptr_inc = rptr_q + ONE;
  assign wr_entry = {seq_q, mem_wrt_i, reg_addr_i, pc_i, instr_i, reg_data_i, mem_addr_i, mem_data_i};
  assign head_cur = mem_q[rptr_q[AW-1:0]];
  assign head_nxt = mem_q[rptr_inc[AW-1:0]];

  // Storage: data only, no reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wr_entry;
  end

  // Control and FSM. tdata is loaded with the beat of the state being entered,
  // so it holds its value while a beat waits for tready.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      tdata_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            state_q <= S_HDR;
            tdata_q <= beat_sel(S_HDR, head_cur);
          end
        end
        S_MDATA: begin
          if (hs) begin
            // Only entries already stored before this edge are chained directly.
            if (count_q > ONE) begin
              state_q <= S_HDR;
              tdata_q <= beat_sel(S_HDR, head_nxt);
            end else begin
              state_q <= S_IDLE;
              tdata_q <= '0;
            end
          end
        end
        default: begin
          if (hs) begin
            state_q <= next_beat(state_q);
            tdata_q <= beat_sel(next_beat(state_q), head_cur);
          end
        end
      endcase

      if (pop)  rptr_q <= rptr_inc;
      if (push) wptr_q <= wptr_q + ONE;
      if (push && !pop)      count_q <= count_q + ONE;
      else if (pop && !push) count_q <= count_q - ONE;
      // The sequence number advances on dropped packets too, so gaps reveal drops.
      if (update_i) seq_q <= seq_q + 8'd1;
      if (drop)     overflow_q <= 1'b1;
    end
  end

`ifdef TRACE_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = '0;
`endif

  assign tvalid_o   = (state_q != S_IDLE);
  assign tlast_o    = (state_q == S_MDATA);
  assign tdata_o    = tdata_q;
  assign level_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_retire_trace_sink.sv
module tb_retire_trace_sink;

  localparam int DEPTH = 8;
`ifdef TRACE_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        clk, rst;
  logic        update_i, mem_wrt_i, tready_i;
  logic [31:0] pc_i, instr_i, reg_data_i, mem_addr_i, mem_data_i;
  logic [4:0]  reg_addr_i;
  logic        tvalid_o, tlast_o, overflow_o;
  logic [31:0] tdata_o;
  logic [3:0]  level_o;
  logic [15:0] drop_cnt_o;

  int checks = 0;
  int errors = 0;

  // Reference model: packet-level view of the sink.
  int          count_m;
  bit          ovf_m;
  int          drops_m;
  logic [7:0]  seq_m;
  int          beats_m;
  bit          pop_m;
  logic [31:0] exp_beats[$];
  logic [31:0] got_beats[$];
  bit          got_last[$];

  retire_trace_sink #(.XLEN(32), .DEPTH(DEPTH), .HDR_TAG(8'hA5)) dut (
    .clk_i(clk), .rst_i(rst), .update_i(update_i), .pc_i(pc_i), .instr_i(instr_i),
    .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .mem_wrt_i(mem_wrt_i), .tvalid_o(tvalid_o),
    .tready_i(tready_i), .tdata_o(tdata_o), .tlast_o(tlast_o), .level_o(level_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change 1ns after the rising edge, so at the falling edge they show
  // exactly what the next rising edge will see. The model advances here.
  always @(negedge clk) begin
    if (!rst) begin
      pop_m = 1'b0;
      if (tvalid_o && tready_i) begin
        got_beats.push_back(tdata_o);
        got_last.push_back(tlast_o);
        beats_m++;
        pop_m = (beats_m % 6 == 0);
      end
      if (update_i) begin
        if (count_m < DEPTH || pop_m) begin
          exp_beats.push_back({8'hA5, seq_m, 10'd0, mem_wrt_i, reg_addr_i});
          exp_beats.push_back(pc_i);
          exp_beats.push_back(instr_i);
          exp_beats.push_back(reg_data_i);
          exp_beats.push_back(mem_addr_i);
          exp_beats.push_back(mem_data_i);
          count_m++;
        end else begin
          ovf_m = 1'b1;
          if (drops_m < 65535) drops_m++;
        end
        seq_m = seq_m + 8'd1;
      end
      if (pop_m) count_m--;
    end
  end

  function automatic logic [15:0] exp_drop();
    logic [15:0] d;
    d = 16'(drops_m);
    return DROP_EN ? d : 16'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    count_m = 0; ovf_m = 1'b0; drops_m = 0; seq_m = 8'd0; beats_m = 0;
    exp_beats.delete(); got_beats.delete(); got_last.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; update_i = 1'b0; tready_i = 1'b0;
    clear_model();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push_pkt(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd,
                          input logic [31:0] rdata, input logic [31:0] maddr,
                          input logic [31:0] mdata, input logic mwrt);
    pc_i = pc; instr_i = instr; reg_addr_i = rd; reg_data_i = rdata;
    mem_addr_i = maddr; mem_data_i = mdata; mem_wrt_i = mwrt; update_i = 1'b1;
    step();
    update_i = 1'b0;
  endtask

  task automatic push_rand();
    push_pkt($urandom, $urandom, 5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
             1'($urandom_range(0, 1)));
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    tready_i = 1'b1;
    while (!(count_m == 0 && !tvalid_o) && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (count_m != 0 || tvalid_o) begin
      errors++;
      $display("FAIL %s drain timeout: level=%0d tvalid=%0b, required level 0 tvalid 0", name, level_o, tvalid_o);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({tvalid_o, tlast_o, overflow_o} !== 3'b000 || tdata_o !== 32'd0 ||
        level_o !== 4'd0 || drop_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: tvalid=%0b tlast=%0b ovf=%0b tdata=%h level=%0d drop=%0d, required all 0",
               tvalid_o, tlast_o, overflow_o, tdata_o, level_o, drop_cnt_o);
    end
  endtask

  task automatic test_single();
    logic [31:0] spec_b[6];
    spec_b = '{32'hA5000001, 32'h10, 32'h00500093, 32'h5, 32'h0, 32'h0};
    do_reset();
    tready_i = 1'b1;
    push_pkt(32'h10, 32'h00500093, 5'd1, 32'd5, 32'd0, 32'd0, 1'b0);
    checks++;
    if (tvalid_o !== 1'b0 || level_o !== 4'd1) begin
      errors++;
      $display("FAIL single_latency_k: tvalid=%0b level=%0d, required 0 / 1", tvalid_o, level_o);
    end
    step();
    checks++;
    if (tvalid_o !== 1'b1 || tdata_o !== 32'hA5000001 || tlast_o !== 1'b0) begin
      errors++;
      $display("FAIL single_header: tvalid=%0b tdata=%h tlast=%0b, required 1 a5000001 0", tvalid_o, tdata_o, tlast_o);
    end
    wait_drain("single");
    checks++;
    if (got_beats.size() != 6 || level_o !== 4'd0) begin
      errors++;
      $display("FAIL single_count: beats=%0d level=%0d, required 6 / 0", got_beats.size(), level_o);
    end
    for (int i = 0; i < 6 && i < got_beats.size(); i++) begin
      checks++;
      if (got_beats[i] !== spec_b[i] || got_last[i] !== (i == 5)) begin
        errors++;
        $display("FAIL single_beat%0d: got %h last=%0b, required %h last=%0b", i, got_beats[i], got_last[i], spec_b[i], i == 5);
      end
    end
    got_beats.delete(); got_last.delete(); exp_beats.delete();
  endtask

  task automatic test_backpressure();
    logic [31:0] hdr;
    tready_i = 1'b0;
    push_rand();
    step();
    hdr = exp_beats[0];
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (tvalid_o !== 1'b1 || tdata_o !== hdr || level_o !== 4'd1) begin
        errors++;
        $display("FAIL backpressure_hold%0d: tvalid=%0b tdata=%h level=%0d, required 1 %h 1", i, tvalid_o, tdata_o, level_o, hdr);
      end
      step();
    end
    wait_drain("backpressure");
    checks++;
    if (got_beats.size() != exp_beats.size()) begin
      errors++;
      $display("FAIL backpressure_count: got %0d beats, required %0d", got_beats.size(), exp_beats.size());
    end
    for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
      checks++;
      if (got_beats[i] !== exp_beats[i] || got_last[i] !== (i % 6 == 5)) begin
        errors++;
        $display("FAIL backpressure_beat%0d: got %h last=%0b, required %h last=%0b", i, got_beats[i], got_last[i], exp_beats[i], i % 6 == 5);
      end
    end
    got_beats.delete(); got_last.delete(); exp_beats.delete();
  endtask

  task automatic test_overflow();
    do_reset();
    tready_i = 1'b0;
    for (int i = 0; i < 9; i++) push_rand();
    checks++;
    if (level_o !== 4'd8 || overflow_o !== 1'b1 || drop_cnt_o !== exp_drop()) begin
      errors++;
      $display("FAIL overflow_flags: level=%0d ovf=%0b drop=%0d, required 8 1 %0d", level_o, overflow_o, drop_cnt_o, exp_drop());
    end
    wait_drain("overflow");
    checks++;
    if (got_beats.size() != 48 || exp_beats.size() != 48) begin
      errors++;
      $display("FAIL overflow_count: got %0d beats, required 48", got_beats.size());
    end
    for (int i = 0; i < 48 && i < got_beats.size() && i < exp_beats.size(); i++) begin
      checks++;
      if (got_beats[i] !== exp_beats[i] || (i % 6 == 0 && got_beats[i][23:16] !== 8'(i / 6))) begin
        errors++;
        $display("FAIL overflow_beat%0d: got %h, required %h", i, got_beats[i], exp_beats[i]);
      end
    end
    got_beats.delete(); got_last.delete(); exp_beats.delete();
    push_rand();
    wait_drain("overflow_next");
    checks++;
    if (got_beats.size() < 1 || got_beats[0][23:16] !== 8'd9 || got_beats[0] !== exp_beats[0]) begin
      errors++;
      $display("FAIL overflow_next_seq: got header %h, required seq 9 header %h",
               got_beats.size() > 0 ? got_beats[0] : 32'hx, exp_beats[0]);
    end
    got_beats.delete(); got_last.delete(); exp_beats.delete();
  endtask

  task automatic test_collision();
    int n;
    do_reset();
    tready_i = 1'b0;
    for (int i = 0; i < 8; i++) push_rand();
    tready_i = 1'b1;
    n = 0;
    while (!(tvalid_o && tlast_o) && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (!(tvalid_o && tlast_o)) begin
      errors++;
      $display("FAIL collision_wait: tvalid=%0b tlast=%0b, required 1 1", tvalid_o, tlast_o);
    end
    push_rand();
    checks++;
    if (level_o !== 4'd8 || overflow_o !== 1'b0 || level_o !== 4'(count_m)) begin
      errors++;
      $display("FAIL collision_level: level=%0d ovf=%0b, required 8 0", level_o, overflow_o);
    end
    wait_drain("collision");
    checks++;
    if (got_beats.size() != 54 || exp_beats.size() != 54) begin
      errors++;
      $display("FAIL collision_count: got %0d beats, required 54", got_beats.size());
    end
    for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
      checks++;
      if (got_beats[i] !== exp_beats[i] || got_last[i] !== (i % 6 == 5)) begin
        errors++;
        $display("FAIL collision_beat%0d: got %h, required %h", i, got_beats[i], exp_beats[i]);
      end
    end
    got_beats.delete(); got_last.delete(); exp_beats.delete();
  endtask

  task automatic test_store();
    do_reset();
    tready_i = 1'b1;
    for (int i = 0; i < 3; i++) push_rand();
    wait_drain("store_pre");
    got_beats.delete(); got_last.delete(); exp_beats.delete();
    push_pkt($urandom, $urandom, 5'd0, $urandom, 32'h100, 32'hDEADBEEF, 1'b1);
    wait_drain("store");
    checks++;
    if (got_beats.size() != 6 || got_beats[0] !== 32'hA5030020 ||
        got_beats[4] !== 32'h100 || got_beats[5] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL store_beats: n=%0d hdr=%h maddr=%h mdata=%h, required 6 a5030020 00000100 deadbeef",
               got_beats.size(), got_beats.size() > 0 ? got_beats[0] : 32'hx,
               got_beats.size() > 4 ? got_beats[4] : 32'hx, got_beats.size() > 5 ? got_beats[5] : 32'hx);
    end
    for (int i = 0; i < 6 && i < got_beats.size(); i++) begin
      checks++;
      if (got_beats[i] !== exp_beats[i]) begin
        errors++;
        $display("FAIL store_beat%0d: got %h, required %h", i, got_beats[i], exp_beats[i]);
      end
    end
    got_beats.delete(); got_last.delete(); exp_beats.delete();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      pc_i = $urandom; instr_i = $urandom; reg_addr_i = 5'($urandom_range(0, 31));
      reg_data_i = $urandom; mem_addr_i = $urandom; mem_data_i = $urandom;
      mem_wrt_i = 1'($urandom_range(0, 1));
      update_i = ($urandom_range(0, 99) < 35);
      tready_i = ($urandom_range(0, 99) < 65);
      step();
      checks++;
      if (level_o !== 4'(count_m) || overflow_o !== ovf_m || drop_cnt_o !== exp_drop()) begin
        errors++;
        $display("FAIL random_status c%0d: level=%0d ovf=%0b drop=%0d, required %0d %0b %0d",
                 c, level_o, overflow_o, drop_cnt_o, count_m, ovf_m, exp_drop());
      end
    end
    update_i = 1'b0;
    wait_drain("random");
    checks++;
    if (got_beats.size() != exp_beats.size()) begin
      errors++;
      $display("FAIL random_count: got %0d beats, required %0d", got_beats.size(), exp_beats.size());
    end
    for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
      checks++;
      if (got_beats[i] !== exp_beats[i] || got_last[i] !== (i % 6 == 5)) begin
        errors++;
        $display("FAIL random_beat%0d: got %h last=%0b, required %h last=%0b", i, got_beats[i], got_last[i], exp_beats[i], i % 6 == 5);
      end
    end
    got_beats.delete(); got_last.delete(); exp_beats.delete();
  endtask

  task automatic test_reset_mid();
    logic [31:0] ipc;
    tready_i = 1'b0;
    push_rand();
    step();
    tready_i = 1'b1;
    step();
    step();
    tready_i = 1'b0;
    checks++;
    if (tvalid_o !== 1'b1 || tdata_o !== exp_beats[2]) begin
      errors++;
      $display("FAIL midreset_instr_beat: tvalid=%0b tdata=%h, required 1 %h", tvalid_o, tdata_o, exp_beats[2]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (tvalid_o !== 1'b0 || tlast_o !== 1'b0 || level_o !== 4'd0 || overflow_o !== 1'b0 || drop_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL midreset_clear: tvalid=%0b level=%0d ovf=%0b drop=%0d, required 0 0 0 0", tvalid_o, level_o, overflow_o, drop_cnt_o);
    end
    clear_model();
    step();
    rst = 1'b0;
    tready_i = 1'b1;
    ipc = $urandom;
    push_pkt(ipc, $urandom, 5'd7, $urandom, $urandom, $urandom, 1'b0);
    step();
    checks++;
    if (tvalid_o !== 1'b1 || tdata_o !== 32'hA5000007) begin
      errors++;
      $display("FAIL midreset_next_hdr: tvalid=%0b tdata=%h, required 1 a5000007", tvalid_o, tdata_o);
    end
    wait_drain("midreset");
    for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
      checks++;
      if (got_beats[i] !== exp_beats[i]) begin
        errors++;
        $display("FAIL midreset_beat%0d: got %h, required %h", i, got_beats[i], exp_beats[i]);
      end
    end
    checks++;
    if (got_beats.size() != 6 || got_beats[1] !== ipc) begin
      errors++;
      $display("FAIL midreset_count: got %0d beats, required 6", got_beats.size());
    end
    got_beats.delete(); got_last.delete(); exp_beats.delete();
  endtask

  initial begin
    rst = 1'b1; update_i = 1'b0; tready_i = 1'b0; mem_wrt_i = 1'b0;
    pc_i = '0; instr_i = '0; reg_addr_i = '0; reg_data_i = '0; mem_addr_i = '0; mem_data_i = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_collision();
    test_store();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
